matrix_ascii_tx: RTL and testbench
==================================

# matrix_ascii_tx

Streams a stored matrix out of the UART as human-readable ASCII decimal text. It is the encoder counterpart of the input parser, which decodes ASCII decimal from `uart_rx`. The block reads elements row-major from matrix storage, converts each signed 32-bit value to decimal digits, and serialises bytes as 8N1 frames. It sits beside the display path and is launched by the FSM controller whenever a matrix must be echoed to the host.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `BIT_CYCLES = CLK_FREQ/BAUD` (integer division), which gives 868 at the defaults.
- `MAX_DIM`, 5: largest legal value of m and n.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous to `clk`, active-high.
- `i_start`  in  1  one-cycle launch pulse.
- `i_base_addr`  in  8  storage address of element (0,0).
- `i_m`  in  32  row count.
- `i_n`  in  32  column count.
- `o_rd_addr`  out  8  storage read address.
- `i_rd_data`  in  32  storage read data, signed. Valid exactly 1 cycle after `o_rd_addr` is presented.
- `uart_tx`  out  1  serial line, idle high.
- `o_busy`  out  1  high from the cycle after an accepted start until the `o_done` cycle.
- `o_done`  out  1  one-cycle pulse when the dump ends.
- `o_err`  out  1  one-cycle pulse, coincident with `o_done`, when the dimensions are illegal.

## Operation
- Reset values: `uart_tx`=1; `o_busy`, `o_done`, `o_err`=0; `o_rd_addr`=0; all counters 0; state IDLE.
- Inputs are latched on `i_start` in IDLE. `i_start` during busy is ignored.
- Dimension check: if m==0, n==0, m>MAX_DIM or n>MAX_DIM, the block emits no bytes. `o_done` and `o_err` pulse on the cycle after start, and `o_busy` stays 0.
- States:
  - IDLE -> FETCH -> WAIT -> CONV.
  - CONV -> SIGN (only if negative) -> DIGITS.
  - DIGITS -> SEP if the element is not last in its row; SEP returns to FETCH.
  - DIGITS -> CR -> LF if the element is last in its row. LF goes to FETCH, or to DONE if it was the last row.
  - DONE -> IDLE.
- Address for element (r,c) is `base + r*n + c`, computed mod 256 so it wraps past 255 to 0.
- Conversion:
  - A negative value emits "-" (0x2D) and converts its two's-complement magnitude. -2147483648 maps to 2147483648 unsigned.
  - Digits are produced by iterative divide-by-10 into a 10-entry buffer and emitted most significant first, with no leading zeros.
  - Value 0 emits "0" (0x30).
- Format: elements in a row are separated by exactly one 0x20. Each row is terminated by 0x0D then 0x0A. There is no trailing space and no extra blank line.
- Serializer frame: start bit 0, data bits LSB first, stop bit 1, each bit BIT_CYCLES clocks.
- Reset asserted mid-operation: the next cycle shows `uart_tx`=1 and state IDLE. No `o_done` is pulsed, and any partial frame is abandoned.

## Timing
- Read latency: 1 cycle. The block registers `i_rd_data` in WAIT.
- Conversion: at most 400 cycles per element, performed while `uart_tx` idles high.
- Within an element, and across the SIGN/DIGITS/SEP/CR/LF sequence, frames are back-to-back. Each start bit begins on the cycle after the previous stop bit completes.
- Start latency: the first falling edge of `uart_tx` occurs no more than 405 cycles after `i_start`.
- End of dump: `o_done` pulses on the cycle after the final LF stop bit completes, and `o_busy` falls in that same cycle.
- A new `i_start` is accepted in the cycle following `o_done`.

## Test plan
- 2x3 matrix at base 0 holding 1..6 -> line carries exactly "1 2 3\r\n4 5 6\r\n" (14 bytes). One `o_done`, `o_err`=0, every bit period 868 cycles.
- 2x4 matrix at base 36 holding the product A×B (23 23 21 17 / 53 56 54 47) -> "23 23 21 17\r\n53 56 54 47\r\n". `o_rd_addr` sequence runs 36..43.
- 1x4 matrix holding 0, -7, 2147483647, -2147483648 -> "0 -7 2147483647 -2147483648\r\n".
- Start with m=0, then with n=6 -> no falling edge on `uart_tx`. `o_done` and `o_err` each pulse once, 1 cycle after start; `o_busy` never rises.
- 1x3 matrix at base 254 -> reads at 254, 255, 0, and the bytes match storage contents.
- Assert `rst` mid-stop-bit of the third byte -> `uart_tx`=1 next cycle and no `o_done`. A fresh start then reproduces the full correct stream, and an `i_start` pulsed while busy produces no second dump.

Source files
------------

// File: rtl/matrix_ascii_tx.sv
// matrix_ascii_tx: reads an m x n matrix row-major from storage, renders each
// signed 32-bit element as ASCII decimal text and shifts the bytes out as 8N1
// UART frames. Elements in a row are separated by one space, and every row
// ends with CR LF.
//
// Launch/complete handshake: i_start is honoured only in IDLE (one-cycle
// pulse, inputs captured in that cycle). o_busy is high from the following
// cycle until the o_done cycle. o_done is a single-cycle pulse, and o_err
// accompanies it when the dimensions were rejected. Storage answers a read
// one cycle after o_rd_addr is presented.
module matrix_ascii_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int MAX_DIM  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [31:0] i_m,
  input  logic [31:0] i_n,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        uart_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int DW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CONV, S_SIGN,
    S_DIGITS, S_SEP, S_CR, S_LF, S_DONE
  } state_t;

  state_t state, state_n;

  // dump bookkeeping
  logic          err_r;
  logic [DW-1:0] m_last, n_last, row, col;

  // conversion datapath: restoring divide-by-10, one quotient bit per cycle
  logic          neg_r;
  logic [31:0]   mag;
  logic [3:0]    rem;
  logic [4:0]    bit_cnt;
  logic [3:0]    dig_cnt, dig_ptr, dig_prev;
  logic [3:0]    digits [10];
  logic [4:0]    rem_sh;
  logic          div_ge;
  logic [3:0]    rem_nx;
  logic [31:0]   quot_nx;
  logic          conv_last, conv_done;

  // serializer
  logic          tx_busy;
  logic [8:0]    tx_frame;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cyc;
  logic          tx_end, tx_load;
  logic [7:0]    tx_data;

  logic          dims_bad, last_col, last_row;

  assign dims_bad = (i_m == 32'd0) || (i_n == 32'd0) ||
                    (i_m > 32'(MAX_DIM)) || (i_n > 32'(MAX_DIM));

  assign last_col = (col == n_last);
  assign last_row = (row == m_last);

  assign rem_sh    = {rem, mag[31]};
  assign div_ge    = (rem_sh >= 5'd10);
  assign rem_nx    = div_ge ? 4'(rem_sh - 5'd10) : rem_sh[3:0];
  assign quot_nx   = {mag[30:0], div_ge};
  assign conv_last = (bit_cnt == 5'd31);
  assign conv_done = (state == S_CONV) && conv_last && (quot_nx == 32'd0);
  assign dig_prev  = dig_ptr - 4'd1;

  // tx_end marks the final cycle of a stop bit; a byte loaded in that same
  // cycle starts its start bit on the very next cycle.
  assign tx_end = tx_busy && (tx_cyc == BIT_LAST) && (tx_bit == 4'd9);

  assign o_busy = (state != S_IDLE) && (state != S_DONE);
  assign o_done = (state == S_DONE);
  assign o_err  = (state == S_DONE) && err_r;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next state; each byte state is entered together with the load of its byte
  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_IDLE:  if (i_start) state_n = dims_bad ? S_DONE : S_FETCH;
      S_FETCH: state_n = S_WAIT;
      S_WAIT:  state_n = S_CONV;
      S_CONV: begin
        if (conv_done) begin
          tx_load = 1'b1;
          if (neg_r) begin
            state_n = S_SIGN;
            tx_data = 8'h2D;
          end else begin
            state_n = S_DIGITS;
            tx_data = {4'h3, rem_nx};
          end
        end
      end
      S_SIGN: begin
        if (tx_end) begin
          state_n = S_DIGITS;
          tx_load = 1'b1;
          tx_data = {4'h3, digits[dig_ptr]};
        end
      end
      S_DIGITS: begin
        if (tx_end) begin
          tx_load = 1'b1;
          if (dig_ptr != 4'd0) begin
            tx_data = {4'h3, digits[dig_prev]};
          end else if (last_col) begin
            state_n = S_CR;
            tx_data = 8'h0D;
          end else begin
            state_n = S_SEP;
            tx_data = 8'h20;
          end
        end
      end
      S_SEP: if (tx_end) state_n = S_FETCH;
      S_CR: begin
        if (tx_end) begin
          state_n = S_LF;
          tx_load = 1'b1;
          tx_data = 8'h0A;
        end
      end
      S_LF:    if (tx_end) state_n = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // launch capture, element fetch, digit generation and position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r     <= 1'b0;
      m_last    <= '0;
      n_last    <= '0;
      row       <= '0;
      col       <= '0;
      o_rd_addr <= 8'd0;
      neg_r     <= 1'b0;
      mag       <= 32'd0;
      rem       <= 4'd0;
      bit_cnt   <= 5'd0;
      dig_cnt   <= 4'd0;
      dig_ptr   <= 4'd0;
      for (int i = 0; i < 10; i++) digits[i] <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            err_r <= dims_bad;
            row   <= '0;
            col   <= '0;
            if (!dims_bad) begin
              o_rd_addr <= i_base_addr;
              m_last    <= DW'(i_m - 32'd1);
              n_last    <= DW'(i_n - 32'd1);
            end
          end
        end
        S_WAIT: begin
          // two's-complement magnitude; 0x80000000 stays 2147483648 unsigned
          neg_r   <= i_rd_data[31];
          mag     <= i_rd_data[31] ? (32'd0 - i_rd_data) : i_rd_data;
          rem     <= 4'd0;
          bit_cnt <= 5'd0;
          dig_cnt <= 4'd0;
        end
        S_CONV: begin
          mag     <= quot_nx;
          rem     <= rem_nx;
          bit_cnt <= bit_cnt + 5'd1;
          if (conv_last) begin
            digits[dig_cnt] <= rem_nx;
            dig_cnt         <= dig_cnt + 4'd1;
            rem             <= 4'd0;
            if (quot_nx == 32'd0) dig_ptr <= dig_cnt;
          end
        end
        S_DIGITS: if (tx_end && (dig_ptr != 4'd0)) dig_ptr <= dig_prev;
        S_SEP: begin
          if (tx_end) begin
            col       <= col + DW'(1);
            o_rd_addr <= o_rd_addr + 8'd1;
          end
        end
        S_LF: begin
          if (tx_end) begin
            col       <= '0;
            row       <= row + DW'(1);
            o_rd_addr <= o_rd_addr + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // 8N1 serializer: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_frame <= 9'h1FF;
      tx_bit   <= 4'd0;
      tx_cyc   <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_load) begin
      tx_busy  <= 1'b1;
      tx_frame <= {1'b1, tx_data};
      tx_bit   <= 4'd0;
      tx_cyc   <= '0;
      uart_tx  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cyc == BIT_LAST) begin
        tx_cyc <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          uart_tx <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          uart_tx  <= tx_frame[0];
          tx_frame <= {1'b1, tx_frame[8:1]};
        end
      end else begin
        tx_cyc <= tx_cyc + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_ascii_tx.sv
// Bench for matrix_ascii_tx: storage model, UART line decoder with a byte
// scoreboard fed from a text-level model of the expected dump, directed tests.
module tb_matrix_ascii_tx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int MAX_DIM  = 5;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_base_addr = 8'd0;
  logic [31:0] i_m = 32'd0;
  logic [31:0] i_n = 32'd0;
  logic [31:0] i_rd_data = 32'd0;
  logic [7:0]  o_rd_addr;
  logic        uart_tx, o_busy, o_done, o_err;

  matrix_ascii_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_m(i_m), .i_n(i_n), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .uart_tx(uart_tx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // storage: one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // printable form: CR -> '~', LF -> '|'
  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "~"};
      else if (s[i] == 8'h0A) r = {r, "|"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // text the host must receive for a matrix held in mem
  function automatic string model_text(input logic [7:0] base, input int m, input int n);
    string s = "";
    logic [7:0] a;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        a = base + 8'(r * n + c);
        s = {s, $sformatf("%0d", $signed(mem[a]))};
        if (c == n - 1) s = $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
        else            s = {s, " "};
      end
    end
    return s;
  endfunction

  // line decoder and byte compare
  int    rx_bit = -1, rx_samp = 0, rx_count = 0, fall_count = 0;
  int    last_end = 0, first_fall = 0;
  bit    first_in_dump = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  string rx_str = "";

  initial begin
    int f, pe;
    bit ok, abort;
    logic [9:0] lvl;
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        f = cyc;
        fall_count++;
        if (first_in_dump) first_fall = f;
        ok = 1'b1;
        abort = 1'b0;
        lvl = '0;
        for (int bi = 0; bi < 10 && !abort; bi++) begin
          for (int s = 0; s < BIT && !abort; s++) begin
            if (bi != 0 || s != 0) @(negedge clk);
            rx_bit = bi;
            rx_samp = s;
            if (rst) abort = 1'b1;
            else if (s == 0) lvl[bi] = uart_tx;
            else if (uart_tx !== lvl[bi]) ok = 1'b0;
          end
        end
        rx_bit = -1;
        if (!abort) begin
          rx_count++;
          pe = last_end;
          last_end = cyc;
          b = lvl[8:1];
          check("frame_shape", {ok, lvl[0], lvl[9]}, 3'b101);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", b, 8'h00);
            if (b == 8'h00) check("unexpected_byte", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("line_byte", b, e);
          end
          if (!first_in_dump && prev_byte != 8'h20 && prev_byte != 8'h0A)
            check("back_to_back", f, pe + 1);
          rx_str = $sformatf("%s%c", rx_str, b);
          prev_byte = b;
          first_in_dump = 1'b0;
        end
      end
    end
  end

  // storage addresses presented during a dump
  logic [7:0] addr_q[$];
  logic       was_busy = 1'b0;
  logic [7:0] last_addr = 8'd0;
  always @(negedge clk) begin
    if (o_busy && (!was_busy || o_rd_addr != last_addr)) addr_q.push_back(o_rd_addr);
    was_busy = o_busy;
    last_addr = o_rd_addr;
  end

  task automatic pulse_start(input logic [7:0] base, input int m, input int n, output int s_cyc);
    @(negedge clk);
    i_base_addr = base;
    i_m = m;
    i_n = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic load_expect(input logic [7:0] base, input int m, input int n, input string lit);
    string model;
    model = model_text(base, m, n);
    check_str("model_pin", vis(model), lit);
    exp_q.delete();
    for (int k = 0; k < model.len(); k++) exp_q.push_back(model[k]);
    rx_str = "";
    addr_q.delete();
    first_in_dump = 1'b1;
  endtask

  task automatic run_dump(input logic [7:0] base, input int m, input int n,
                          input string lit, input bit poke);
    int s_cyc, budget, f0;
    bit done_seen, quiet_ok;
    load_expect(base, m, n, lit);
    pulse_start(base, m, n, s_cyc);
    check("busy_after_start", o_busy, 1);
    check("no_done_at_start", o_done, 0);
    budget = lit.len() * 10 * BIT + m * n * 400 + 1000;
    done_seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        done_seen = 1'b1;
        break;
      end
      i_start = poke && (i == 300);
    end
    i_start = 1'b0;
    check("done_seen", done_seen, 1);
    if (done_seen) begin
      check("busy_low_at_done", o_busy, 0);
      check("err_low_at_done", o_err, 0);
      check("done_after_last_stop", cyc, last_end + 1);
      check("bytes_left", exp_q.size(), 0);
      check_str("line_text", vis(rx_str), lit);
      check("start_latency", (first_fall > s_cyc && first_fall - s_cyc <= 405), 1);
      check("addr_count", addr_q.size(), m * n);
      for (int k = 0; k < addr_q.size() && k < m * n; k++)
        check("rd_addr", addr_q[k], (int'(base) + k) & 255);
    end
    f0 = fall_count;
    quiet_ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (o_done || o_busy) quiet_ok = 1'b0;
    end
    check("quiet_after_done", quiet_ok, 1);
    check("no_extra_frames", fall_count, f0);
  endtask

  task automatic run_bad(input int m, input int n);
    int s_cyc, f0;
    bit quiet_ok;
    exp_q.delete();
    f0 = fall_count;
    pulse_start(8'd10, m, n, s_cyc);
    check("bad_done_pulse", o_done, 1);
    check("bad_err_pulse", o_err, 1);
    check("bad_busy_low", o_busy, 0);
    @(negedge clk);
    check("bad_done_single", o_done, 0);
    check("bad_err_single", o_err, 0);
    quiet_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_busy || o_done || o_err) quiet_ok = 1'b0;
    end
    check("bad_quiet", quiet_ok, 1);
    check("bad_no_frames", fall_count, f0);
  endtask

  // main sequence
  initial begin
    int s_cyc, r0;
    bit hit, quiet_ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (5) @(negedge clk);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_err", o_err, 0);
    check("reset_rd_addr", o_rd_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_uart_tx", uart_tx, 1);

    // 2x3 at base 0 holding 1..6
    for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
    run_dump(8'd0, 2, 3, "1 2 3~|4 5 6~|", 1'b0);

    // reset during the stop bit of the third byte, then a clean dump with a
    // stray start while busy
    load_expect(8'd0, 2, 3, "1 2 3~|4 5 6~|");
    r0 = rx_count;
    pulse_start(8'd0, 2, 3, s_cyc);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_count == r0 + 2 && rx_bit == 9 && rx_samp >= BIT / 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_third_stop", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_line_high", uart_tx, 1);
    check("rst_busy_low", o_busy, 0);
    check("rst_no_done", o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    quiet_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done || o_busy || uart_tx !== 1'b1) quiet_ok = 1'b0;
    end
    check("rst_quiet", quiet_ok, 1);
    run_dump(8'd0, 2, 3, "1 2 3~|4 5 6~|", 1'b1);

    // 2x4 product at base 36
    mem[36] = 32'd23; mem[37] = 32'd23; mem[38] = 32'd21; mem[39] = 32'd17;
    mem[40] = 32'd53; mem[41] = 32'd56; mem[42] = 32'd54; mem[43] = 32'd47;
    run_dump(8'd36, 2, 4, "23 23 21 17~|53 56 54 47~|", 1'b0);

    // extremes: zero, small negative, INT_MAX, INT_MIN
    mem[100] = 32'h0000_0000; mem[101] = 32'hFFFF_FFF9;
    mem[102] = 32'h7FFF_FFFF; mem[103] = 32'h8000_0000;
    run_dump(8'd100, 1, 4, "0 -7 2147483647 -2147483648~|", 1'b0);

    // illegal dimensions
    run_bad(0, 3);
    run_bad(2, 6);

    // address wrap past 255
    mem[254] = 32'd42; mem[255] = 32'hFFFF_FFF3; mem[0] = 32'd907;
    run_dump(8'd254, 1, 3, "42 -13 907~|", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
